chaotic_lfsr_gen: RTL and testbench

//  Parametrised chaotic-LFSR keystream generator, successor of the single-bit chaos source.

---
 rtl/chaotic_lfsr_gen.sv | 137 +++++++++++++
 tb/tb_chaotic_lfsr_gen.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/chaotic_lfsr_gen.sv
// Chaotic keystream generator: Galois LFSR perturbed and whitened by a Q0.16 logistic map,
// with the generated bits packed MSB-first into words on a valid/ready stream.
module chaotic_lfsr_gen #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] TAPS      = WIDTH'(16'hB400),
    parameter logic [WIDTH-1:0] SEED_LFSR = WIDTH'(16'h0001),
    parameter logic [15:0]      SEED_X    = 16'h8000,
    parameter logic [15:0]      R_Q       = 16'hF5C3,
    parameter int               OUT_W     = 8,
    parameter int               PERTURB   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_lfsr,
    input  logic [15:0]      seed_x,
    output logic             bit_out,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int CW = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int PW = (PERTURB > 1) ? $clog2(PERTURB) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(OUT_W - 1);
    localparam logic [PW-1:0] PERT_LAST = (PERTURB > 0) ? PW'(PERTURB - 1) : '0;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD
    } mode_e;

    mode_e            mode;
    logic             step;

    logic [WIDTH-1:0] lfsr;
    logic [15:0]      x;
    logic [PW-1:0]    pert_cnt;
    logic [CW-1:0]    bit_cnt;
    logic [OUT_W-1:0] shreg;

    logic [31:0]      prod_p;
    logic [31:0]      prod_q;
    logic [15:0]      m_val;
    logic [15:0]      x_raw;
    logic [15:0]      x_next;
    logic             lb;
    logic             gen_bit;
    logic             perturb_now;
    logic [WIDTH-1:0] lfsr_next;
    logic [PW-1:0]    pert_next;
    logic             word_done;
    logic [OUT_W-1:0] shift_next;

    // HOLD outranks enable: a word waiting on the consumer stalls everything.
    always_comb begin
        mode = IDLE;
        if (out_valid && !out_ready) begin
            mode = HOLD;
        end else if (enable) begin
            mode = RUN;
        end
    end

    assign step = (mode == RUN) && !seed_load;

    // Logistic map x' = r*x*(1-x); saturates on overflow and escapes fixed points / zero.
    always_comb begin
        prod_p = {16'd0, x} * {16'd0, 16'hFFFF - x};
        m_val  = 16'(prod_p >> 16);
        prod_q = {16'd0, m_val} * {16'd0, R_Q};
        x_raw  = (prod_q >= 32'h4000_0000) ? 16'hFFFF : 16'(prod_q >> 14);
        x_next = x_raw;
        if (x_raw == 16'd0 || x_raw == x) begin
            x_next = SEED_X;
        end
    end

    always_comb begin
        lb          = lfsr[0];
        gen_bit     = lb ^ x[15];
        perturb_now = (PERTURB != 0) && (pert_cnt == PERT_LAST);
        lfsr_next   = (lfsr >> 1) ^ (lb ? TAPS : '0);
        if (perturb_now) begin
            lfsr_next = lfsr_next ^ WIDTH'(x_next);
        end
        if (lfsr_next == '0) begin
            lfsr_next = WIDTH'(1);
        end
        pert_next = (PERTURB <= 1 || pert_cnt == PERT_LAST) ? '0 : pert_cnt + PW'(1);
        word_done  = (bit_cnt == BIT_LAST);
        shift_next = OUT_W'({shreg, gen_bit});
    end

    // A new word completing on a transfer edge keeps out_valid high with fresh data.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr      <= SEED_LFSR;
            x         <= SEED_X;
            pert_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            bit_out   <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (seed_load) begin
            lfsr      <= (seed_lfsr == '0) ? WIDTH'(1) : seed_lfsr;
            x         <= (seed_x == 16'd0) ? SEED_X : seed_x;
            pert_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            out_valid <= 1'b0;
        end else begin
            if (step) begin
                lfsr     <= lfsr_next;
                x        <= x_next;
                pert_cnt <= pert_next;
                bit_out  <= gen_bit;
                shreg    <= shift_next;
                if (word_done) begin
                    out_data <= shift_next;
                    bit_cnt  <= '0;
                end else begin
                    bit_cnt <= bit_cnt + CW'(1);
                end
            end
            if (step && word_done) begin
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_chaotic_lfsr_gen.sv
// Directed bench for chaotic_lfsr_gen: two instances (PERTURB=0 and PERTURB=4) share stimulus
// and are checked against hand-computed constants and a small bit-level reference model.
module tb_chaotic_lfsr_gen;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        enable    = 1'b0;
    logic        seed_load = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] seed_lfsr = '0;
    logic [15:0] seed_x    = '0;

    logic        bit_out0, bit_out4, out_valid0, out_valid4;
    logic [7:0]  out_data0, out_data4;

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  first_word;

    logic [15:0] m_lfsr  [2];
    logic [15:0] m_x     [2];
    int          m_pc    [2];
    int          m_bc    [2];
    logic [7:0]  m_sh    [2];
    logic [7:0]  m_data  [2];
    logic        m_valid [2];
    logic        m_bit   [2];

    always #5 clk = ~clk;

    chaotic_lfsr_gen #(.PERTURB(0)) dut0 (
        .clk(clk), .rst(rst), .enable(enable), .seed_load(seed_load),
        .seed_lfsr(seed_lfsr), .seed_x(seed_x), .bit_out(bit_out0),
        .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready)
    );

    chaotic_lfsr_gen #(.PERTURB(4)) dut4 (
        .clk(clk), .rst(rst), .enable(enable), .seed_load(seed_load),
        .seed_lfsr(seed_lfsr), .seed_x(seed_x), .bit_out(bit_out4),
        .out_data(out_data4), .out_valid(out_valid4), .out_ready(out_ready)
    );

    function automatic logic [15:0] m_logistic(input logic [15:0] xv);
        logic [31:0] p, q;
        logic [15:0] mm, r;
        p  = {16'h0, xv} * {16'h0, 16'hFFFF - xv};
        mm = p[31:16];
        q  = {16'h0, mm} * 32'h0000_F5C3;
        r  = (q[31:30] != 2'b00) ? 16'hFFFF : q[29:14];
        if (r == 16'h0 || r == xv) r = 16'h8000;
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_lfsr[k] = 16'h0001; m_x[k] = 16'h8000; m_pc[k] = 0; m_bc[k] = 0;
            m_sh[k] = 8'h0; m_data[k] = 8'h0; m_valid[k] = 1'b0; m_bit[k] = 1'b0;
        end
    endtask

    task automatic model_edge();
        int          per;
        logic        st, xfer, done, lb, b;
        logic [15:0] xn, ln;
        for (int k = 0; k < 2; k++) begin
            per = (k == 0) ? 0 : 4;
            if (seed_load) begin
                m_lfsr[k] = (seed_lfsr == 16'h0) ? 16'h0001 : seed_lfsr;
                m_x[k]    = (seed_x == 16'h0) ? 16'h8000 : seed_x;
                m_pc[k] = 0; m_bc[k] = 0; m_sh[k] = 8'h0; m_valid[k] = 1'b0;
            end else begin
                st   = enable && !(m_valid[k] && !out_ready);
                xfer = m_valid[k] && out_ready;
                done = 1'b0;
                if (st) begin
                    lb = m_lfsr[k][0];
                    b  = lb ^ m_x[k][15];
                    xn = m_logistic(m_x[k]);
                    ln = (m_lfsr[k] >> 1) ^ (lb ? 16'hB400 : 16'h0000);
                    if (per != 0 && m_pc[k] == per - 1) ln = ln ^ xn;
                    m_pc[k] = (per == 0 || m_pc[k] == per - 1) ? 0 : m_pc[k] + 1;
                    if (ln == 16'h0) ln = 16'h0001;
                    m_lfsr[k] = ln;
                    m_x[k]    = xn;
                    m_bit[k]  = b;
                    m_sh[k]   = {m_sh[k][6:0], b};
                    if (m_bc[k] == 7) begin
                        m_data[k] = m_sh[k];
                        m_bc[k]   = 0;
                        done      = 1'b1;
                    end else begin
                        m_bc[k] = m_bc[k] + 1;
                    end
                end
                if (done) m_valid[k] = 1'b1;
                else if (xfer) m_valid[k] = 1'b0;
            end
        end
    endtask

    // Model advances with the inputs seen by the coming edge; outputs sampled 1ns after it.
    task automatic tick();
        if (rst) model_reset();
        else model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; seed_load = 1'b0; out_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (dut0.lfsr !== 16'h0001) begin failures++; $display("[TB] FAIL reset_lfsr got=%h exp=0001", dut0.lfsr); end
        checks++; if (dut0.x !== 16'h8000) begin failures++; $display("[TB] FAIL reset_x got=%h exp=8000", dut0.x); end
        checks++; if (bit_out0 !== 1'b0) begin failures++; $display("[TB] FAIL reset_bit got=%b exp=0", bit_out0); end
        checks++; if (out_data0 !== 8'h00) begin failures++; $display("[TB] FAIL reset_data got=%h exp=00", out_data0); end
        checks++; if (out_valid0 !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b exp=0", out_valid0); end
        checks++; if (dut4.lfsr !== 16'h0001) begin failures++; $display("[TB] FAIL reset_lfsr4 got=%h exp=0001", dut4.lfsr); end
    endtask

    task automatic test_lfsr_sequence();
        logic [15:0] exp_l [3] = '{16'hB400, 16'h5A00, 16'h2D00};
        enable = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (dut0.lfsr !== exp_l[i]) begin failures++; $display("[TB] FAIL lfsr_step%0d got=%h exp=%h", i + 1, dut0.lfsr, exp_l[i]); end
            checks++; if (dut4.lfsr !== exp_l[i]) begin failures++; $display("[TB] FAIL lfsr4_step%0d got=%h exp=%h", i + 1, dut4.lfsr, exp_l[i]); end
            if (i == 0) begin
                checks++; if (dut0.x !== 16'hF5BF) begin failures++; $display("[TB] FAIL x_step1 got=%h exp=F5BF", dut0.x); end
                checks++; if (bit_out0 !== 1'b0) begin failures++; $display("[TB] FAIL bit_step1 got=%b exp=0", bit_out0); end
            end
            if (i == 1) begin
                checks++; if (bit_out0 !== 1'b1) begin failures++; $display("[TB] FAIL bit_step2 got=%b exp=1", bit_out0); end
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_hold();
        int          n;
        int          bad;
        logic [15:0] held_lfsr;
        do_reset();
        out_ready = 1'b0; enable = 1'b1;
        n = 0;
        while (out_valid0 !== 1'b1 && n < 20) begin tick(); n++; end
        checks++; if (n != 8) begin failures++; $display("[TB] FAIL hold_first_valid cycles=%0d exp=8", n); end
        checks++; if (out_data0 !== m_data[0]) begin failures++; $display("[TB] FAIL hold_first_word got=%h exp=%h", out_data0, m_data[0]); end
        first_word = m_data[0];
        held_lfsr  = m_lfsr[0];
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid0 !== 1'b1 || out_data0 !== first_word || dut0.lfsr !== held_lfsr ||
                bit_out0 !== m_bit[0] || out_data4 !== m_data[1] || dut4.lfsr !== m_lfsr[1]) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("[TB] FAIL hold_frozen bad_cycles=%0d exp=0", bad); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (out_valid0 !== 1'b0) begin failures++; $display("[TB] FAIL hold_transfer got=%b exp=0", out_valid0); end
        n = 1;
        while (out_valid0 !== 1'b1 && n < 20) begin tick(); n++; end
        checks++; if (n != 8) begin failures++; $display("[TB] FAIL hold_next_valid cycles=%0d exp=8", n); end
        checks++; if (out_data0 !== m_data[0]) begin failures++; $display("[TB] FAIL hold_second_word got=%h exp=%h", out_data0, m_data[0]); end
    endtask

    task automatic test_seed_zero();
        logic prev_bit;
        prev_bit  = m_bit[0];
        seed_load = 1'b1; seed_lfsr = 16'h0000; seed_x = 16'h0000;
        tick();
        seed_load = 1'b0;
        checks++; if (dut0.lfsr !== 16'h0001) begin failures++; $display("[TB] FAIL seed0_lfsr got=%h exp=0001", dut0.lfsr); end
        checks++; if (dut0.x !== 16'h8000) begin failures++; $display("[TB] FAIL seed0_x got=%h exp=8000", dut0.x); end
        checks++; if (out_valid0 !== 1'b0) begin failures++; $display("[TB] FAIL seed0_valid got=%b exp=0", out_valid0); end
        checks++; if (bit_out0 !== prev_bit) begin failures++; $display("[TB] FAIL seed0_nostep got=%b exp=%b", bit_out0, prev_bit); end
        out_ready = 1'b1; enable = 1'b1;
        tick();
        checks++; if (dut0.lfsr !== 16'hB400) begin failures++; $display("[TB] FAIL seed0_first_step got=%h exp=B400", dut0.lfsr); end
        for (int i = 0; i < 7; i++) tick();
        checks++; if (out_valid0 !== 1'b1 || out_data0 !== first_word) begin failures++; $display("[TB] FAIL seed0_word got=%b/%h exp=1/%h", out_valid0, out_data0, first_word); end
        enable = 1'b0;
        seed_load = 1'b1; seed_lfsr = 16'h1234; seed_x = 16'h4000;
        tick();
        seed_load = 1'b0;
        checks++; if (dut0.lfsr !== 16'h1234 || dut0.x !== 16'h4000) begin failures++; $display("[TB] FAIL seed_load_value got=%h/%h exp=1234/4000", dut0.lfsr, dut0.x); end
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 0; i < 64; i++) begin
            enable    = !(i >= 20 && i < 24);
            out_ready = (i < 32) ? 1'b1 : ((i % 3) != 0);
            tick();
            checks++; if (out_valid0 !== m_valid[0]) begin failures++; $display("[TB] FAIL stream_valid0 cyc=%0d got=%b exp=%b", i, out_valid0, m_valid[0]); end
            if (m_valid[0]) begin
                checks++; if (out_data0 !== m_data[0]) begin failures++; $display("[TB] FAIL stream_data0 cyc=%0d got=%h exp=%h", i, out_data0, m_data[0]); end
            end
            checks++; if (dut0.lfsr !== m_lfsr[0]) begin failures++; $display("[TB] FAIL stream_lfsr0 cyc=%0d got=%h exp=%h", i, dut0.lfsr, m_lfsr[0]); end
            checks++; if (out_valid4 !== m_valid[1]) begin failures++; $display("[TB] FAIL stream_valid4 cyc=%0d got=%b exp=%b", i, out_valid4, m_valid[1]); end
            if (m_valid[1]) begin
                checks++; if (out_data4 !== m_data[1]) begin failures++; $display("[TB] FAIL stream_data4 cyc=%0d got=%h exp=%h", i, out_data4, m_data[1]); end
            end
            checks++; if (dut4.lfsr !== m_lfsr[1] || dut4.x !== m_x[1]) begin failures++; $display("[TB] FAIL stream_state4 cyc=%0d got=%h/%h exp=%h/%h", i, dut4.lfsr, dut4.x, m_lfsr[1], m_x[1]); end
            checks++; if (bit_out4 !== m_bit[1]) begin failures++; $display("[TB] FAIL stream_bit4 cyc=%0d got=%b exp=%b", i, bit_out4, m_bit[1]); end
            checks++; if (dut4.lfsr === 16'h0 || dut4.x === 16'h0) begin failures++; $display("[TB] FAIL stream_nonzero cyc=%0d got=%h/%h exp=nonzero", i, dut4.lfsr, dut4.x); end
        end
        enable = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        enable = 1'b1; out_ready = 1'b0;
        n = 0;
        while (out_valid0 !== 1'b1 && n < 20) begin tick(); n++; end
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (out_valid0 !== 1'b0 || out_data0 !== 8'h00 || bit_out0 !== 1'b0) begin failures++; $display("[TB] FAIL rst_hold_outputs got=%b/%h/%b exp=0/00/0", out_valid0, out_data0, bit_out0); end
        checks++; if (dut0.lfsr !== 16'h0001 || dut0.x !== 16'h8000) begin failures++; $display("[TB] FAIL rst_hold_state got=%h/%h exp=0001/8000", dut0.lfsr, dut0.x); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (out_valid0 !== 1'b0 || out_data0 !== 8'h00 || bit_out0 !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_outputs got=%b/%h/%b exp=0/00/0", out_valid0, out_data0, bit_out0); end
        checks++; if (dut0.lfsr !== 16'h0001 || dut0.x !== 16'h8000) begin failures++; $display("[TB] FAIL rst_mid_state got=%h/%h exp=0001/8000", dut0.lfsr, dut0.x); end
        n = 0;
        while (out_valid0 !== 1'b1 && n < 20) begin tick(); n++; end
        checks++; if (n != 8 || out_data0 !== first_word) begin failures++; $display("[TB] FAIL rst_mid_restart cycles=%0d data=%h exp=8/%h", n, out_data0, first_word); end
        enable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lfsr_sequence();
        test_hold();
        test_seed_zero();
        test_stream();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
